// File: rtl/dotp_pkg.sv
// -----------------------------------------------------------------------------
// dotp_pkg
// Shared definitions for the element-serial dot-product engine:
//   - default vector length, element width and index width
//   - accumulator width derivation
//   - FSM state encoding
// Optional build macro used by the engine: DOTP_SIGNED_EN (signed operands).
// -----------------------------------------------------------------------------
package dotp_pkg;

    localparam int DOTP_N    = 64;  // vector length
    localparam int DOTP_DW   = 8;   // operand element width
    localparam int DOTP_IDXW = 7;   // index counter width

    // Product needs 2*dw bits; summing n of them needs clog2(n) more so the
    // accumulator can never overflow.
    function automatic int dotp_accw(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dotp_state_e;

endpackage

// File: rtl/dotp_mac.sv
// -----------------------------------------------------------------------------
// dotp_mac
// Multiply-accumulate stage: registers one operand product per valid input
// and folds it into the accumulator one cycle later.
//   clk, rstn  clock, async active-low reset
//   clr        clear accumulator and product-valid (start of a new vector)
//   in_vld     a/b hold an element pair to multiply this cycle
//   a, b       selected operand elements
//   sum        accumulator + current product (next accumulator value)
// Build option: DOTP_SIGNED_EN selects two's-complement operands and
// sign-extension; otherwise operands are unsigned and zero-extended.
// -----------------------------------------------------------------------------
import dotp_pkg::*;

module dotp_mac #(
    parameter int DW   = DOTP_DW,
    parameter int ACCW = dotp_accw(DOTP_DW, DOTP_N)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr,
    input  logic            in_vld,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] sum
);

    logic [2*DW-1:0] a_ext;
    logic [2*DW-1:0] b_ext;
    logic [2*DW-1:0] prod_nxt;
    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] prod_ext;
    logic            prod_vld;
    logic [ACCW-1:0] acc;

    // Operands are widened to the product width first, so the low 2*DW bits
    // of the multiply are the exact product in either number system.
`ifdef DOTP_SIGNED_EN
    assign a_ext    = (2*DW)'($signed(a));
    assign b_ext    = (2*DW)'($signed(b));
    assign prod_ext = ACCW'($signed(prod));
`else
    assign a_ext    = (2*DW)'(a);
    assign b_ext    = (2*DW)'(b);
    assign prod_ext = ACCW'(prod);
`endif

    assign prod_nxt = a_ext * b_ext;
    assign sum      = acc + prod_ext;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else if (clr) begin
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod_vld <= in_vld;
            if (in_vld) begin
                prod <= prod_nxt;
            end
            if (prod_vld) begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/dot_product_seq.sv
// -----------------------------------------------------------------------------
// dot_product_seq
// Element-serial dot-product engine. Drives an external index counter's
// enable, uses the returned count to select an operand pair, and accumulates
// N products. The sum is presented on a valid/ready output; any gap or jump
// in the index sequence raises a sticky error.
// Ports:
//   clk, rstn        clock, async active-low reset
//   start            request, honoured only when idle
//   a_vec, b_vec     operand vectors, element i at [i*DW +: DW]; stable while busy
//   idx_en           enable to the index counter (combinational)
//   idx              counter value; all-ones when idle
//   busy             engine not idle
//   result           dot product (two's-complement bits in the signed build)
//   out_valid        result valid; held until out_ready
//   out_ready        consumer accept
//   err              sticky index-sequence error, cleared by the next start
// Build option: DOTP_SIGNED_EN -> signed operands and result.
// -----------------------------------------------------------------------------
import dotp_pkg::*;

module dot_product_seq #(
    parameter int N    = DOTP_N,
    parameter int DW   = DOTP_DW,
    parameter int IDXW = DOTP_IDXW,
    parameter int ACCW = dotp_accw(DOTP_DW, DOTP_N)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [N*DW-1:0] a_vec,
    input  logic [N*DW-1:0] b_vec,
    output logic            idx_en,
    input  logic [IDXW-1:0] idx,
    output logic            busy,
    output logic [ACCW-1:0] result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            err
);

    dotp_state_e     state;
    dotp_state_e     state_nxt;
    logic            idx_vld;     // idx carries an element this cycle
    logic [IDXW-1:0] exp_idx;     // index the counter should be showing
    logic            accept;
    logic            last;
    logic [DW-1:0]   a_sel;
    logic [DW-1:0]   b_sel;
    logic [ACCW-1:0] sum;

    assign accept = (state == IDLE) && start;
    assign last   = idx_vld && (idx == IDXW'(N - 1));
    assign busy   = (state != IDLE);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                // Drop the enable in the same cycle the last index is seen so
                // the counter returns to all-ones instead of running past N-1.
                idx_en = !last;
                if (last) state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand select by the index as received; an out-of-range index
    // contributes zero rather than reading past the vector.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDXW'(i)) begin
                a_sel = a_vec[i*DW +: DW];
                b_sel = b_vec[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            idx_vld   <= 1'b0;
            exp_idx   <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            state     <= state_nxt;
            idx_vld   <= idx_en;
            out_valid <= (state_nxt == DONE);
            if (accept) begin
                exp_idx <= '0;
                err     <= 1'b0;
            end else if (idx_vld) begin
                exp_idx <= exp_idx + 1'b1;
                if (idx != exp_idx) err <= 1'b1;
            end
            // The last product is folded in during DRAIN, so capture the
            // completed sum directly from the adder.
            if (state == DRAIN) result <= sum;
        end
    end

    dotp_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (accept),
        .in_vld (idx_vld),
        .a      (a_sel),
        .b      (b_sel),
        .sum    (sum)
    );

endmodule

// File: tb/tb_dot_product_seq.sv
// -----------------------------------------------------------------------------
// tb_dot_product_seq
// Bench for dot_product_seq with a behavioural model of the upstream index
// counter (all-ones when disabled, +1 per enabled cycle, optional 5->7 jump).
// Expected sums come from a plain arithmetic model of the dot product.
// Honours DOTP_SIGNED_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_dot_product_seq;

    localparam int N    = 64;
    localparam int DW   = 8;
    localparam int IDXW = 7;
    localparam int ACCW = 2 * DW + $clog2(N);

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic [N*DW-1:0] a_vec;
    logic [N*DW-1:0] b_vec;
    logic            idx_en;
    logic [IDXW-1:0] idx;
    logic            busy;
    logic [ACCW-1:0] result;
    logic            out_valid;
    logic            out_ready;
    logic            err;
    logic            skip_en;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dot_product_seq dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .idx_en    (idx_en),
        .idx       (idx),
        .busy      (busy),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    // Index counter stand-in.
    always @(posedge clk or negedge rstn) begin
        if (!rstn)        idx <= '1;
        else if (!idx_en) idx <= '1;
        else if (skip_en && idx == IDXW'(5)) idx <= IDXW'(7);
        else              idx <= idx + 1'b1;
    end

    function automatic logic [ACCW-1:0] model(input logic [N*DW-1:0] a,
                                              input logic [N*DW-1:0] b,
                                              input int skip_idx);
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] ai;
            logic [DW-1:0] bi;
            ai = a[i*DW +: DW];
            bi = b[i*DW +: DW];
            if (i != skip_idx) begin
`ifdef DOTP_SIGNED_EN
                s += longint'($signed(ai)) * longint'($signed(bi));
`else
                s += longint'(ai) * longint'(bi);
`endif
            end
        end
        return ACCW'(s);
    endfunction

    // Entered #1 after a rising edge with the engine idle; that cycle is the
    // start cycle (cycle 0).
    task automatic run_op(input string name, input logic [N*DW-1:0] a,
                          input logic [N*DW-1:0] b, input int hold,
                          input bit skip, input bit stray);
        logic [ACCW-1:0] exp;
        int cyc;
        int en_low;
        int n_el;
        int extra;
        bit stable;
        exp       = model(a, b, skip ? 6 : -1);
        n_el      = skip ? N - 1 : N;
        a_vec     = a;
        b_vec     = b;
        skip_en   = skip;
        out_ready = (hold == 0);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        total++;
        if ({idx_en, idx, err, busy} !== {1'b1, {IDXW{1'b1}}, 1'b0, 1'b1})
            $display("FAIL %s cycle1 en/idx/err/busy: got %b %h %b %b want 1 %h 0 1",
                     name, idx_en, idx, err, busy, {IDXW{1'b1}});
        else passed++;
        en_low = 0;
        while (!out_valid && cyc < 300) begin
            start = stray && (cyc == 10);
            @(posedge clk); #1;
            cyc++;
            if (!idx_en && en_low == 0) en_low = cyc;
        end
        start = 1'b0;
        total++;
        if (cyc !== n_el + 3)
            $display("FAIL %s out_valid cycle: got %0d want %0d", name, cyc, n_el + 3);
        else passed++;
        total++;
        if (en_low !== n_el + 1)
            $display("FAIL %s idx_en low cycle: got %0d want %0d", name, en_low, n_el + 1);
        else passed++;
        total++;
        if (result !== exp)
            $display("FAIL %s result: got %0h want %0h", name, result, exp);
        else passed++;
        total++;
        if (err !== skip)
            $display("FAIL %s err: got %b want %b", name, err, skip);
        else passed++;
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!(out_valid === 1'b1 && result === exp)) stable = 1'b0;
            end
            total++;
            if (!stable)
                $display("FAIL %s backpressure hold: valid=%b result=%0h want 1 %0h",
                         name, out_valid, result, exp);
            else passed++;
        end
        out_ready = 1'b1;
        start     = stray;   // start in the handshake cycle must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if ({out_valid, busy} !== 2'b00)
            $display("FAIL %s after handshake valid/busy: got %b%b want 00",
                     name, out_valid, busy);
        else passed++;
        if (stray) begin
            extra = 0;
            for (int i = 0; i < N + 8; i++) begin
                @(posedge clk); #1;
                if (out_valid || busy) extra++;
            end
            total++;
            if (extra !== 0)
                $display("FAIL %s stray start activity: got %0d cycles want 0",
                         name, extra);
            else passed++;
        end
    endtask

    task automatic fill(output logic [N*DW-1:0] v, input int mode, input int val);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       v[i*DW +: DW] = DW'(val);
                1:       v[i*DW +: DW] = DW'(i);
                default: v[i*DW +: DW] = DW'($urandom);
            endcase
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; out_ready = 1'b0; skip_en = 1'b0;
        a_vec = '0; b_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, idx_en, out_valid, err, result} !== '0)
            $display("FAIL reset outputs: got %b%b%b%b %0h want all zero",
                     busy, idx_en, out_valid, err, result);
        else passed++;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [N*DW-1:0] a, b;
        fill(a, 0, 1); fill(b, 0, 1);
        run_op("ones", a, b, 0, 1'b0, 1'b0);
        fill(a, 1, 0); fill(b, 0, 2);
        run_op("ramp_bp", a, b, 10, 1'b0, 1'b0);
    endtask

    task automatic test_extremes();
        logic [N*DW-1:0] a, b;
`ifdef DOTP_SIGNED_EN
        fill(a, 0, -128); fill(b, 0, 127);
`else
        fill(a, 0, 255); fill(b, 0, 255);
`endif
        run_op("extreme", a, b, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [N*DW-1:0] a, b;
        for (int t = 0; t < 3; t++) begin
            fill(a, 2, 0); fill(b, 2, 0);
            run_op($sformatf("rand%0d", t), a, b, t, 1'b0, 1'b0);
        end
    endtask

    task automatic test_idx_err();
        logic [N*DW-1:0] a, b;
        fill(a, 2, 0); fill(b, 2, 0);
        run_op("skip", a, b, 0, 1'b1, 1'b0);
        fill(a, 2, 0); fill(b, 2, 0);
        run_op("after_skip", a, b, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        logic [N*DW-1:0] a, b;
        fill(a, 2, 0); fill(b, 2, 0);
        a_vec = a; b_vec = b; skip_en = 1'b0; out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) begin @(posedge clk); #1; end
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({busy, idx_en, out_valid, err, result} !== '0)
            $display("FAIL midrun reset outputs: got %b%b%b%b %0h want all zero",
                     busy, idx_en, out_valid, err, result);
        else passed++;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, idx_en, idx} !== {2'b00, {IDXW{1'b1}}})
            $display("FAIL post-reset idle busy/en/idx: got %b%b %h want 00 %h",
                     busy, idx_en, idx, {IDXW{1'b1}});
        else passed++;
        run_op("after_reset", a, b, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [N*DW-1:0] a, b;
        fill(a, 2, 0); fill(b, 2, 0);
        run_op("b2b_0", a, b, 0, 1'b0, 1'b0);
        fill(a, 2, 0); fill(b, 2, 0);
        run_op("b2b_1", a, b, 0, 1'b0, 1'b0);
        fill(a, 2, 0); fill(b, 2, 0);
        run_op("stray_start", a, b, 2, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_random();
        test_idx_err();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dot_product_seq.md
# dot_product_seq

Element-serial dot-product engine for the 64x64 vector multiplier datapath. Sits directly downstream of the 7-bit index counter: it drives the counter's enable, consumes the count as an element index, multiplies the selected operand pair and accumulates over N elements. Presents the final sum on a valid/ready output and flags index-sequence errors.

## Interface
- N, 64, vector length; 1 ≤ N ≤ 2^IDXW − 1.
- DW, 8, operand element width.
- IDXW, 7, index width; must match the counter width.
- ACCW, 2*DW + clog2(N), accumulator/result width; 22 at defaults.
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- a_vec  in  N*DW  operand A; element i at [i*DW +: DW]; held stable while busy=1.
- b_vec  in  N*DW  operand B; same layout and rule.
- idx_en  out  1  enable to the index counter.
- idx  in  IDXW  counter value; all-ones = idle, increments by 1 per enabled cycle.
- busy  out  1  high in every state except IDLE.
- result  out  ACCW  dot product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- err  out  1  sticky index-sequence error.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset: state=IDLE; idx_en, busy, out_valid, err = 0; result, accumulator, product register, expected index = 0.
- IDLE: start=1 → RUN; clear accumulator, expected index and err.
- RUN: idx_en=1, except when idx_vld=1 and idx=N−1, where idx_en=0 (combinational).
- idx_vld: register holding the previous cycle's idx_en.
- When idx_vld=1: product register ← a_vec[idx]*b_vec[idx]; prod_vld ← 1; expected index increments.
- Last element (idx_vld=1 and idx=N−1): → DRAIN.
- If idx_vld=1 and idx ≠ expected index: err ← 1 (sticky until next accepted start). The element is still consumed using idx as received.
- Accumulator ← accumulator + product whenever prod_vld=1.
- DRAIN: final accumulation → DONE.
- DONE: out_valid=1; result holds until out_ready=1.
- Handshake out_valid & out_ready → IDLE; out_valid low the next cycle.
- start is ignored outside IDLE, including in the handshake cycle.
- Arithmetic:
  - Product is 2*DW bits; accumulator is ACCW bits.
  - ACCW is sized so overflow cannot occur.
  - Operands signed per Configuration.
- Asynchronous reset mid-operation:
  - Immediate return to IDLE.
  - idx_en drops, returning the counter to all-ones.
  - No partial result is presented.

## Timing
- start sampled in cycle 0.
- Cycle 1: idx_en=1 and idx=all-ones.
- Cycle k+2: idx=k, for k = 0..N−1.
- Cycle N+1: idx=N−1 and idx_en=0.
- Cycle N+2: DRAIN.
- Cycle N+3: out_valid=1. This is N+3 cycles after the start cycle (67 at N=64).
- Minimum start-to-start interval: N+4 cycles, with out_ready tied high.
- out_valid and result are registered outputs.
- idx_en is combinational from state, idx_vld and idx.

## Configuration
- DOTP_SIGNED_EN defined: elements are two's complement, products and accumulator are sign-extended, and result is signed.
- DOTP_SIGNED_EN undefined: elements are unsigned, with zero-extension.
- Width and timing are identical in both builds.

## Structure
- Package dotp_pkg holds:
  - State encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3).
  - Default N/DW/IDXW constants.
  - ACCW derivation function.
- Sub-module dotp_mac holds the product register, prod_vld and accumulator, with clear, valid and operand inputs.
- The top level holds:
  - FSM.
  - idx_vld / expected-index tracking.
  - Operand mux.
  - Output handshake.
- The bench instantiates the existing index counter alongside.

## Test plan
- All a=1, b=1, N=64, out_ready=1 → result=64; out_valid in cycle 67; err=0.
- a[i]=i, b[i]=2 → result=4032. With out_ready held low for 10 cycles, result is stable and out_valid stays high.
- Signed build, a all −128, b all 127 → result=−1040384. Unsigned build, a all 255, b all 255 → result=4161600.
- Force idx to skip from 5 to 7 → err=1 at completion; next start clears err.
- Assert rstn low in cycle 30 of RUN → outputs zero, idx_en=0, state IDLE; a following start produces a correct result.
- start pulsed while busy and in the handshake cycle → ignored; exactly one result per accepted start.
